// File: rtl/eth_rx_pkt_reader.sv
// eth_rx_pkt_reader: drains one packet per command-FIFO entry from the data FIFO, forwarding
// good packets through a 2-entry skid buffer. Define RX_STAT_EN to build the stat_* counters.
module eth_rx_pkt_reader #(
    parameter logic [10:0] MIN_LEN   = 11'd60,
    parameter int          OUT_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_fifo_empty,
    output logic        cmd_fifo_rd,
    input  logic [71:0] cmd_fifo_dout,
    input  logic        data_fifo_empty,
    output logic        data_fifo_rd,
    input  logic [8:0]  data_fifo_dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [10:0] out_len,
    output logic [31:0] stat_good,
    output logic [31:0] stat_crc_err,
    output logic [31:0] stat_delete,
    output logic [31:0] stat_runt
);

    localparam logic [2:0] SKID_LIMIT = 3'(OUT_DEPTH);

    typedef enum logic [2:0] {IDLE, CMD_WAIT, DECIDE, FWD, DROP} state_t;

    state_t      state_q, state_d;
    logic [10:0] len_q, len_d;
    logic        crc_q, crc_d;
    logic        del_q, del_d;
    logic [10:0] rd_cnt_q, rd_cnt_d;
    logic        pend_q, pend_d;
    logic        pend_sop_q, pend_sop_d;
    logic        pend_eop_q, pend_eop_d;
    logic        head_v_q, head_v_d;
    logic [9:0]  head_q, head_d;
    logic        tail_v_q, tail_v_d;
    logic [9:0]  tail_q, tail_d;

    logic        pop;
    logic        fwd_rd;
    logic        drop_rd;
    logic        last_rd;
    logic        good_done;
    logic        drop_done;
    logic [2:0]  credit;
    logic [9:0]  in_entry;
    logic        unused_bits;

    assign unused_bits = ^{cmd_fifo_dout[71:54], cmd_fifo_dout[51:11], data_fifo_dout[8]};

    // Credit counts the skid slots still owed after this cycle's pop, so a byte can be
    // requested in the same cycle the head drains and one byte per cycle is sustained.
    always_comb begin
        pop       = head_v_q & out_ready;
        credit    = 3'(head_v_q) + 3'(tail_v_q) + 3'(pend_q) - 3'(pop);
        last_rd   = (rd_cnt_q + 11'd1) == len_q;
        fwd_rd    = ~reset & (state_q == FWD) & ~data_fifo_empty
                    & (rd_cnt_q < len_q) & (credit < SKID_LIMIT);
        drop_rd   = ~reset & (state_q == DROP) & ~data_fifo_empty & (rd_cnt_q < len_q);
        good_done = (state_q == FWD) & pop & head_q[9];
        drop_done = drop_rd & last_rd;
        in_entry  = {pend_eop_q, pend_sop_q, data_fifo_dout[7:0]};
    end

    assign cmd_fifo_rd  = ~reset & (state_q == IDLE) & ~cmd_fifo_empty;
    assign data_fifo_rd = fwd_rd | drop_rd;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        crc_d      = crc_q;
        del_d      = del_q;
        rd_cnt_d   = rd_cnt_q;
        pend_d     = fwd_rd;
        pend_sop_d = (rd_cnt_q == 11'd0);
        pend_eop_d = last_rd;
        case (state_q)
            IDLE: begin
                if (cmd_fifo_rd) state_d = CMD_WAIT;
            end
            CMD_WAIT: begin
                len_d   = cmd_fifo_dout[10:0];
                crc_d   = cmd_fifo_dout[53];
                del_d   = cmd_fifo_dout[52];
                state_d = DECIDE;
            end
            DECIDE: begin
                rd_cnt_d = 11'd0;
                if (len_q == 11'd0)                          state_d = IDLE;
                else if (crc_q || del_q || (len_q < MIN_LEN)) state_d = DROP;
                else                                         state_d = FWD;
            end
            FWD: begin
                if (fwd_rd)    rd_cnt_d = rd_cnt_q + 11'd1;
                if (good_done) state_d  = IDLE;
            end
            DROP: begin
                if (drop_rd)   rd_cnt_d = rd_cnt_q + 11'd1;
                if (drop_done) state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry skid: head drives the outputs, tail only fills while the head is stalled.
    always_comb begin
        head_v_d = head_v_q;
        head_d   = head_q;
        tail_v_d = tail_v_q;
        tail_d   = tail_q;
        if (pop) begin
            if (tail_v_q) begin
                head_d   = tail_q;
                tail_v_d = pend_q;
                tail_d   = pend_q ? in_entry : 10'd0;
            end else if (pend_q) begin
                head_d = in_entry;
            end else begin
                head_v_d = 1'b0;
                head_d   = 10'd0;
            end
        end else if (pend_q) begin
            if (!head_v_q) begin
                head_v_d = 1'b1;
                head_d   = in_entry;
            end else begin
                tail_v_d = 1'b1;
                tail_d   = in_entry;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= 11'd0;
            crc_q      <= 1'b0;
            del_q      <= 1'b0;
            rd_cnt_q   <= 11'd0;
            pend_q     <= 1'b0;
            pend_sop_q <= 1'b0;
            pend_eop_q <= 1'b0;
            head_v_q   <= 1'b0;
            head_q     <= 10'd0;
            tail_v_q   <= 1'b0;
            tail_q     <= 10'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            crc_q      <= crc_d;
            del_q      <= del_d;
            rd_cnt_q   <= rd_cnt_d;
            pend_q     <= pend_d;
            pend_sop_q <= pend_sop_d;
            pend_eop_q <= pend_eop_d;
            head_v_q   <= head_v_d;
            head_q     <= head_d;
            tail_v_q   <= tail_v_d;
            tail_q     <= tail_d;
        end
    end

    assign out_valid = head_v_q;
    assign out_data  = head_q[7:0];
    assign out_sop   = head_q[8];
    assign out_eop   = head_q[9];
    assign out_len   = out_sop ? len_q : 11'd0;

`ifdef RX_STAT_EN
    typedef enum logic [1:0] {CLS_CRC, CLS_DEL, CLS_RUNT} drop_cls_t;

    drop_cls_t   cls_q, cls_d;
    logic [31:0] good_cnt_q, good_cnt_d;
    logic [31:0] crc_cnt_q, crc_cnt_d;
    logic [31:0] del_cnt_q, del_cnt_d;
    logic [31:0] runt_cnt_q, runt_cnt_d;

    // CRC error outranks delete, which outranks runt, when a packet carries several flags.
    always_comb begin
        cls_d      = cls_q;
        good_cnt_d = good_cnt_q;
        crc_cnt_d  = crc_cnt_q;
        del_cnt_d  = del_cnt_q;
        runt_cnt_d = runt_cnt_q;
        if (state_q == DECIDE) begin
            if (crc_q)      cls_d = CLS_CRC;
            else if (del_q) cls_d = CLS_DEL;
            else            cls_d = CLS_RUNT;
        end
        if (good_done) good_cnt_d = good_cnt_q + 32'd1;
        if (drop_done) begin
            case (cls_q)
                CLS_CRC:  crc_cnt_d  = crc_cnt_q + 32'd1;
                CLS_DEL:  del_cnt_d  = del_cnt_q + 32'd1;
                CLS_RUNT: runt_cnt_d = runt_cnt_q + 32'd1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cls_q      <= CLS_CRC;
            good_cnt_q <= 32'd0;
            crc_cnt_q  <= 32'd0;
            del_cnt_q  <= 32'd0;
            runt_cnt_q <= 32'd0;
        end else begin
            cls_q      <= cls_d;
            good_cnt_q <= good_cnt_d;
            crc_cnt_q  <= crc_cnt_d;
            del_cnt_q  <= del_cnt_d;
            runt_cnt_q <= runt_cnt_d;
        end
    end

    assign stat_good    = good_cnt_q;
    assign stat_crc_err = crc_cnt_q;
    assign stat_delete  = del_cnt_q;
    assign stat_runt    = runt_cnt_q;
`else
    assign stat_good    = 32'h0;
    assign stat_crc_err = 32'h0;
    assign stat_delete  = 32'h0;
    assign stat_runt    = 32'h0;
`endif

endmodule
